// File: rtl/hash_out_serializer.sv
// hash_out_serializer: captures the final 512-bit BLAKE2 state and streams
// the first nn digest bytes, least-significant byte first, as a byte-wide
// valid stream. Optional slow mode holds each byte for SLOW_DIV cycles.
// Optional feature macro: HASH_OUT_OVERRUN_EN adds a sticky overrun_o flag
// that records any h_v_i pulse dropped while the serializer was busy.
module hash_out_serializer #(
  parameter int SLOW_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         h_v_i,
  input  logic [511:0] h_i,
  input  logic [5:0]   nn_i,
  input  logic         slow_i,
`ifdef HASH_OUT_OVERRUN_EN
  output logic         overrun_o,
`endif
  output logic         ready_v_o,
  output logic         hash_v_o,
  output logic [7:0]   hash_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [3:0] DIV_LAST = 4'(SLOW_DIV - 1);

  state_t        state_q, state_d;
  logic [511:0]  sr_q, sr_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [3:0]    div_q, div_d;
  logic          slow_q, slow_d;
  logic          ready_q, ready_d;
  logic          hash_v_q, hash_v_d;
  logic [7:0]    hash_q, hash_d;

  // Next-state and registered-output computation for the IDLE/SEND machine.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    slow_d   = slow_q;
    ready_d  = ready_q;
    hash_v_d = hash_v_q;
    hash_d   = hash_q;
    case (state_q)
      ST_IDLE: begin
        ready_d  = 1'b1;
        hash_v_d = 1'b0;
        if (h_v_i && (nn_i != 6'd0)) begin
          // Byte 0 is presented straight from h_i so it shows in cycle 1.
          sr_d     = h_i;
          cnt_d    = nn_i;
          slow_d   = slow_i;
          div_d    = 4'd0;
          state_d  = ST_SEND;
          hash_d   = h_i[7:0];
          hash_v_d = 1'b1;
          ready_d  = 1'b0;
        end else begin
          // nn_i = 0 accepts are consumed silently; nothing else to do.
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!slow_q || (div_q == DIV_LAST)) begin
          div_d = 4'd0;
          if (cnt_q == 6'd1) begin
            // Last byte finished: hash_o keeps its value, only valid drops.
            cnt_d    = 6'd0;
            state_d  = ST_IDLE;
            hash_v_d = 1'b0;
            ready_d  = 1'b1;
          end else begin
            sr_d     = {8'd0, sr_q[511:8]};
            cnt_d    = cnt_q - 6'd1;
            hash_d   = sr_q[15:8];
            hash_v_d = 1'b1;
            ready_d  = 1'b0;
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = 6'd0;
        div_d    = 4'd0;
        ready_d  = 1'b1;
        hash_v_d = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      div_q    <= 4'd0;
      slow_q   <= 1'b0;
      ready_q  <= 1'b1;
      hash_v_q <= 1'b0;
      hash_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      slow_q   <= slow_d;
      ready_q  <= ready_d;
      hash_v_q <= hash_v_d;
      hash_q   <= hash_d;
    end
  end

  // Digest shift register; deliberately not reset, it is reloaded on accept.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign ready_v_o = ready_q;
  assign hash_v_o  = hash_v_q;
  assign hash_o    = hash_q;

`ifdef HASH_OUT_OVERRUN_EN
  logic overrun_q, overrun_d;

  // A pulse arriving while not ready is dropped; remember it until reset.
  always_comb begin
    overrun_d = overrun_q | (h_v_i & ~ready_q);
  end

  // Sticky overrun flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_o = overrun_q;
`endif

endmodule

// File: tb/tb_hash_out_serializer.sv
// Self-checking bench for hash_out_serializer: directed cases from the
// intended behaviour plus randomized streams checked against a byte-level
// reference (byte k = byte k mod 8 of word h[k/8], held 1 or SLOW_DIV cycles).
module tb_hash_out_serializer;

  localparam int SD = 4;

  logic         clk;
  logic         reset;
  logic         h_v_i;
  logic [511:0] h_i;
  logic [5:0]   nn_i;
  logic         slow_i;
  logic         ready_v_o;
  logic         hash_v_o;
  logic [7:0]   hash_o;
`ifdef HASH_OUT_OVERRUN_EN
  logic         overrun_o;
`endif

  int checks;
  int failures;
  logic [7:0] last_byte;   // expected hash_o between streams
  logic       ov_exp;      // expected overrun flag

  hash_out_serializer #(.SLOW_DIV(SD)) dut (
    .clk       (clk),
    .reset     (reset),
    .h_v_i     (h_v_i),
    .h_i       (h_i),
    .nn_i      (nn_i),
    .slow_i    (slow_i),
`ifdef HASH_OUT_OVERRUN_EN
    .overrun_o (overrun_o),
`endif
    .ready_v_o (ready_v_o),
    .hash_v_o  (hash_v_o),
    .hash_o    (hash_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the idle-state outputs against the reference.
  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(ready_v_o), 64'd1);
    chk({tag, "_valid"}, 64'(hash_v_o), 64'd0);
    chk({tag, "_hold"}, 64'(hash_o), 64'(last_byte));
`ifdef HASH_OUT_OVERRUN_EN
    chk({tag, "_ovr"}, 64'(overrun_o), 64'(ov_exp));
`endif
  endtask

  function automatic logic [511:0] pack(input logic [63:0] w [8]);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = w[i];
    return r;
  endfunction

  // Reference byte k: byte (k mod 8) of word h[k/8], little-endian words.
  function automatic logic [7:0] ref_byte(input logic [63:0] w [8], input int k);
    logic [63:0] word;
    word = w[k / 8];
    return 8'(word >> (8 * (k % 8)));
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Accept a hash in the current cycle and check the whole stream.
  // extra_hv_at: cycle (1-based) in which a second h_v_i is pulsed, 0 = none.
  task automatic run_stream(input logic [63:0] w [8], input int nn, input bit slow,
                            input int extra_hv_at, input string tag);
    int d;
    int total;
    d = slow ? SD : 1;
    total = nn * d;
    h_i    = pack(w);
    nn_i   = 6'(nn);
    slow_i = slow;
    h_v_i  = 1'b1;
    step();
    h_v_i  = 1'b0;
    h_i    = rand512();
    nn_i   = 6'($urandom);
    slow_i = 1'($urandom);
    for (int cyc = 1; cyc <= total; cyc++) begin
      chk({tag, "_v"}, 64'(hash_v_o), 64'd1);
      chk({tag, "_rdy"}, 64'(ready_v_o), 64'd0);
      chk({tag, "_byte"}, 64'(hash_o), 64'(ref_byte(w, (cyc - 1) / d)));
`ifdef HASH_OUT_OVERRUN_EN
      chk({tag, "_ovr"}, 64'(overrun_o), 64'(ov_exp));
`endif
      if (cyc == extra_hv_at) begin
        h_v_i  = 1'b1;
        ov_exp = 1'b1;
      end
      step();
      h_v_i = 1'b0;
    end
    if (nn > 0) last_byte = ref_byte(w, nn - 1);
    chk_idle({tag, "_end"});
  endtask

  logic [63:0] hw [8];
  logic [63:0] rw [8];

  initial begin
    checks    = 0;
    failures  = 0;
    last_byte = 8'd0;
    ov_exp    = 1'b0;
    reset  = 1'b1;
    h_v_i  = 1'b0;
    h_i    = '0;
    nn_i   = 6'd0;
    slow_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle("reset_idle");
    end

    // Sequential-byte pattern: h[i] bytes are 8i..8i+7.
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 8; b++) hw[i][8*b +: 8] = 8'(8 * i + b);

    run_stream(hw, 12, 1'b0, 0, "fast12");
    run_stream(hw, 3, 1'b1, 0, "slow3");
    run_stream(hw, 63, 1'b0, 0, "fast63");
    chk("nn63_last", 64'(last_byte), 64'h3E);
    run_stream(hw, 12, 1'b0, 5, "overlap");
    run_stream(hw, 0, 1'b0, 0, "nn0");
    step();
    chk_idle("nn0_after");

    // Reset in cycle 4 of a 12-byte stream, with a simultaneous h_v_i.
    h_i = pack(hw); nn_i = 6'd12; slow_i = 1'b0; h_v_i = 1'b1;
    step();
    h_v_i = 1'b0;
    for (int cyc = 1; cyc < 4; cyc++) begin
      chk("rst_pre_byte", 64'(hash_o), 64'(ref_byte(hw, cyc - 1)));
      step();
    end
    reset = 1'b1; h_v_i = 1'b1;
    step();
    reset = 1'b0; h_v_i = 1'b0;
    last_byte = 8'd0;
    ov_exp    = 1'b0;
    chk_idle("rst_mid");
    step();
    chk_idle("rst_mid2");
    run_stream(hw, 12, 1'b0, 0, "post_rst");

    // Randomized streams with random idle gaps.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++) rw[i] = {$urandom, $urandom};
      run_stream(rw, int'($urandom_range(0, 63)), 1'($urandom), 0, "rand");
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        step();
        chk_idle("rand_gap");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hash_out_serializer.md
# hash_out_serializer

Output stage of the BLAKE2 datapath, directly upstream of the I/O interface's `hash_v_i` / `hash_i` / `ready_v_i` inputs.

- Captures the final 512-bit chaining state from the compression core when the core signals completion.
- Streams the first `nn_i` bytes, least-significant byte first, as a byte-wide valid stream toward the output pins.
- Advertises readiness for the next hash. Honours the slow-output mode selected at the I/O interface.

## Interface
Parameters:
- `SLOW_DIV`, default 4: cycles each byte is held in slow mode. Legal range 2..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `h_v_i`  in  1: one-cycle pulse; final hash available on `h_i`.
- `h_i`  in  512: final state h[0..7], h[0] in bits 63:0, each word little-endian.
- `nn_i`  in  6: digest length in bytes (config `nn`); sampled on accept.
- `slow_i`  in  1: slow-output mode (from `slow_output_o`); sampled on accept.
- `ready_v_o`  out  1: serializer idle; next `h_v_i` will be accepted.
- `hash_v_o`  out  1: `hash_o` carries a valid digest byte.
- `hash_o`  out  8: digest byte.

## Operation
- States: IDLE, SEND.
- IDLE:
  - `ready_v_o`=1.
  - `h_v_i`=1 with `nn_i`≠0: load a 512-bit shift register from `h_i`, load `cnt` := `nn_i`, latch `slow_q` := `slow_i`, clear `div` := 0, go to SEND.
  - `h_v_i` with `nn_i`=0: accepted, no bytes emitted, stay in IDLE.
- SEND:
  - Present shift register bits 7:0 on `hash_o` and assert `hash_v_o`.
  - Fast (`slow_q`=0): every cycle shift right 8 and decrement `cnt`.
  - Slow (`slow_q`=1): `div` counts 0..SLOW_DIV-1. `hash_o` and `hash_v_o` stay stable for SLOW_DIV cycles. Shift and decrement only when `div`=SLOW_DIV-1, then `div` := 0.
  - When the byte with `cnt`=1 completes, go to IDLE.
- `h_v_i` in SEND is ignored. No queueing; the in-flight stream is unaffected.
- `nn_i` / `slow_i` changes during SEND have no effect until the next accept.
- Byte k of the stream (k=0..nn-1) is byte k mod 8 of word h[k/8].
- `nn_i` values above 64 are impossible: the port is 6 bits, max 63.
- `cnt` is 6 bits and `div` is 4 bits. Neither wraps: both are reloaded on accept.

## Timing
- All outputs are registered.
- Reset values: `ready_v_o`=1, `hash_v_o`=0, `hash_o`=0, state IDLE, `cnt`=0, `div`=0. The shift register is not reset.
- Accept at cycle 0 (`h_v_i`=1 and `ready_v_o`=1). Then:
  - `ready_v_o`=0 from cycle 1.
  - First byte on `hash_o` with `hash_v_o`=1 in cycle 1.
- Fast mode:
  - Bytes appear in cycles 1..nn.
  - `hash_v_o`=0 and `ready_v_o`=1 in cycle nn+1.
  - Earliest next accept is cycle nn+1.
- Slow mode:
  - Byte k is held in cycles 1+k·SLOW_DIV .. (k+1)·SLOW_DIV.
  - `ready_v_o`=1 in cycle nn·SLOW_DIV+1.
- `hash_o` between streams keeps its last driven byte. Only `hash_v_o` qualifies it.
- `nn_i`=0 accept: `ready_v_o` stays 1 and `hash_v_o` stays 0.
- Reset asserted mid-stream: the next cycle shows reset values and the stream is abandoned. `h_v_i` in the same cycle as `reset` is ignored.

## Configuration
- Macro `HASH_OUT_OVERRUN_EN`.
- Defined:
  - Adds output `overrun_o` (1 bit), reset 0.
  - Set sticky in the cycle after any `h_v_i`=1 seen while `ready_v_o`=0.
  - Cleared only by `reset`.
- Undefined: port and logic absent. Dropped `h_v_i` pulses are silent.

## Test plan
- Reset, then hold `h_v_i`=0 for 5 cycles → `ready_v_o`=1, `hash_v_o`=0, `hash_o`=0 throughout.
- `h_i` with h[0]=64'h0706050403020100, h[1]=64'h0F0E0D0C0B0A0908, `nn_i`=12, `slow_i`=0, pulse at cycle 0 → `hash_o`=00,01,…,0B in cycles 1..12 with `hash_v_o`=1; `ready_v_o`=0 in cycles 1..12 and 1 in cycle 13.
- Same `h_i`, `nn_i`=3, `slow_i`=1, SLOW_DIV=4 → `hash_o`=00 in cycles 1–4, 01 in cycles 5–8, 02 in cycles 9–12; `ready_v_o`=1 in cycle 13.
- `nn_i`=63 with all h bytes distinct → 63 bytes in order ending with h[7] byte 6; h[7] byte 7 is never emitted.
- Second `h_v_i` at cycle 5 of a 12-byte stream → stream unchanged. With `HASH_OUT_OVERRUN_EN`, `overrun_o`=1 from cycle 6 until reset.
- `reset` at cycle 4 of a 12-byte stream → cycle 5 shows `hash_v_o`=0, `ready_v_o`=1. A new accept at cycle 6 streams cleanly from byte 0. Also: `nn_i`=0 accept → no `hash_v_o`, `ready_v_o` stays 1.
